hd_uart_loader: RTL and testbench

HD_UART_LOADER -- requirements
Module: hd_uart_loader

---
 rtl/hd_uart_loader_pkg.sv | 25 ++
 rtl/hd_uart_loader_uart_rx.sv | 108 ++++++++++
 rtl/hd_uart_loader.sv | 165 ++++++++++++++++
 tb/tb_hd_uart_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_uart_loader_pkg.sv
// Package shared by the UART loader slice.
// Holds the loader FSM state type, the UART receiver state type and the
// default bit-period constant for a 50 MHz clock at 115200 baud.
package hd_uart_loader_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/hd_uart_loader_uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk_i        - clock, all state on rising edge
//   rst_ni       - asynchronous active-low reset
//   rx_i         - serial line, idle high, asynchronous to clk_i
//   byte_o       - last received byte (valid with byte_valid_o)
//   byte_valid_o - one-cycle pulse, byte received with a good stop bit
//   frame_err_o  - one-cycle pulse, stop bit sampled low (byte dropped)
module uart_rx
    import hd_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned     CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) valid_d = 1'b1;
                    else         ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/hd_uart_loader.sv
// UART loader: receives a length-prefixed, big-endian word stream over UART
// and writes each word into the Hard_Disk memory.
// Ports:
//   clk        - 50 MHz clock
//   reset      - asynchronous active-low reset
//   rx         - UART serial line (8N1, idle high)
//   start      - one-cycle pulse arming a load session
//   hd_addr    - Hard_Disk write address
//   hd_data    - Hard_Disk write data
//   hd_write   - Hard_Disk write strobe, one cycle per word
//   busy       - session in progress
//   done       - session completed (held until start/reset)
//   error      - framing or length error (held until start/reset)
//   word_count - words written in current/last session
module hd_uart_loader
    import hd_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] hd_addr,
    output logic [DATA_WIDTH-1:0] hd_data,
    output logic                  hd_write,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned MAX_WORDS = (ADDR_WIDTH >= 16) ? 32'd65535 : (32'd1 << ADDR_WIDTH);

    // Reset asserts asynchronously, releases on clk through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    ld_state_e             state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            idx_q, idx_d;
    logic [15:0]           wc_q, wc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [15:0]           len_new;
    logic [DATA_WIDTH-1:0] word_new;
    logic [15:0]           wc_inc;

    assign len_new  = {len_hi_q, rx_byte};
    assign word_new = {word_q[DATA_WIDTH-9:0], rx_byte};
    assign wc_inc   = wc_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            wc_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            wc_q     <= wc_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        word_d   = word_q;
        idx_d    = idx_q;
        wc_d     = wc_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wc_d    = '0;
                    idx_d   = '0;
                end
            end
            S_LEN_HI: begin
                if (rx_ferr) state_d = S_ERROR;
                else if (rx_valid) begin
                    len_hi_d = rx_byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_ferr) state_d = S_ERROR;
                else if (rx_valid) begin
                    len_d = len_new;
                    if (len_new == '0)                   state_d = S_DONE;
                    else if (32'(len_new) > MAX_WORDS)   state_d = S_ERROR;
                    else                                 state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_ferr) state_d = S_ERROR;
                else if (rx_valid) begin
                    word_d = word_new;
                    if (idx_q == 8'(BYTES - 1)) begin
                        // Address/data latched here so they are stable for
                        // the whole WRITE cycle.
                        idx_d   = '0;
                        addr_d  = ADDR_WIDTH'(wc_q);
                        data_d  = word_new;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_WRITE: begin
                wc_d    = wc_inc;
                state_d = (wc_inc == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hd_write   = (state_q == S_WRITE);
    assign busy       = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign word_count = wc_q;
    assign hd_addr    = addr_q;
    assign hd_data    = data_q;

endmodule

// File: tb/tb_hd_uart_loader.sv
// Self-checking bench for hd_uart_loader with an 8-clock bit period.
module tb_hd_uart_loader;

    localparam int CPB = 8;
    localparam int AW  = 10;
    localparam int DW  = 32;

    logic          clk, reset, rx, start;
    logic [AW-1:0] hd_addr;
    logic [DW-1:0] hd_data;
    logic          hd_write, busy, done, error;
    logic [15:0]   word_count;

    hd_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .start      (start),
        .hd_addr    (hd_addr),
        .hd_data    (hd_data),
        .hd_write   (hd_write),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    int byte_pulses = 0;
    logic prev_wr = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        string         name;
        int            nb;
        logic [7:0]    b[10];
        int            bad_idx;
        int            nw;
        logic [AW-1:0] wa[2];
        logic [DW-1:0] wd[2];
        logic          e_done;
        logic          e_err;
        int            e_wc;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write strobe pops one expected write.
    always @(negedge clk) begin
        wr_t e;
        if (hd_write) begin
            wr_count++;
            if (prev_wr) begin
                total++; bad++;
                $display("FAIL wr_width: hd_write high %0d consecutive cycles, expected 1", 2);
            end
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: addr %0h data %0h, expected no write", hd_addr, hd_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(hd_addr), 64'(e.addr));
                check("wr_data", 64'(hd_data), 64'(e.data));
            end
        end
        prev_wr = hd_write;
        if (dut.u_rx.byte_valid_o) byte_pulses++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy %0d after %0d cycles, expected 0", busy, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"two_words", 10,
                    '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67},
                    -1, 2, '{10'd0, 10'd1}, '{32'hDEADBEEF, 32'h01234567}, 1'b1, 1'b0, 2};
        vecs[1] = '{"zero_len", 2,
                    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    -1, 0, '{10'd0, 10'd0}, '{32'h0, 32'h0}, 1'b1, 1'b0, 0};
        vecs[2] = '{"frame_err", 7,
                    '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h00},
                    6, 1, '{10'd0, 10'd0}, '{32'hDEADBEEF, 32'h0}, 1'b0, 1'b1, 1};
        vecs[3] = '{"too_long", 2,
                    '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    -1, 0, '{10'd0, 10'd0}, '{32'h0, 32'h0}, 1'b0, 1'b1, 0};
        vecs[4] = '{"len_hi_err", 1,
                    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 0, '{10'd0, 10'd0}, '{32'h0, 32'h0}, 1'b0, 1'b1, 0};

        reset = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hd_write", 64'(hd_write), 64'd0);
        check("rst_hd_addr", 64'(hd_addr), 64'd0);
        check("rst_hd_data", 64'(hd_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Bytes with no session armed are ignored.
        wr_count = 0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        check("nostart_busy", 64'(busy), 64'd0);
        check("nostart_writes", 64'(wr_count), 64'd0);

        // Table-driven sessions.
        for (int v = 0; v < 5; v++) begin
            wr_count = 0;
            for (int w = 0; w < vecs[v].nw; w++) push_wr(vecs[v].wa[w], vecs[v].wd[w]);
            pulse_start();
            check({vecs[v].name, "_busy_start"}, 64'(busy), 64'd1);
            for (int i = 0; i < vecs[v].nb; i++)
                send_byte(vecs[v].b[i], (i != vecs[v].bad_idx));
            wait_idle();
            check({vecs[v].name, "_done"}, 64'(done), 64'(vecs[v].e_done));
            check({vecs[v].name, "_error"}, 64'(error), 64'(vecs[v].e_err));
            check({vecs[v].name, "_word_count"}, 64'(word_count), 64'(vecs[v].e_wc));
            check({vecs[v].name, "_busy_end"}, 64'(busy), 64'd0);
            check({vecs[v].name, "_writes"}, 64'(wr_count), 64'(vecs[v].nw));
            check({vecs[v].name, "_pending"}, 64'(exp_q.size()), 64'd0);
        end

        // Single word, with a start pulse mid-word that must be ignored.
        wr_count = 0;
        push_wr(10'd0, 32'h11223344);
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        pulse_start();
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_idle();
        check("one_word_done", 64'(done), 64'd1);
        check("one_word_count", 64'(word_count), 64'd1);
        check("one_word_writes", 64'(wr_count), 64'd1);

        // Reset in the middle of the second word.
        wr_count = 0;
        push_wr(10'd0, 32'hDEADBEEF);
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_word_count", 64'(word_count), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_hd_write", 64'(hd_write), 64'd0);
        check("mid_rst_hd_addr", 64'(hd_addr), 64'd0);
        check("mid_rst_hd_data", 64'(hd_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        check("mid_rst_word_count", 64'(word_count), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h45, 1'b1);
        send_byte(8'h67, 1'b1);
        repeat (10) @(negedge clk);
        check("post_rst_writes", 64'(wr_count), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

        // One-cycle low glitch in IDLE yields no byte; a real byte does.
        byte_pulses = 0;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_byte", 64'(byte_pulses), 64'd0);
        send_byte(8'h5A, 1'b1);
        check("idle_byte_seen", 64'(byte_pulses), 64'd1);
        check("idle_byte_no_write", 64'(wr_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
